// File: rtl/clint_1_13_pkg.sv
// Shared definitions for the v1.13 machine-mode CLINT.
//   - register offsets inside the 64 KiB window
//   - bus FSM state type, 64-bit timer type
//   - byte-lane merge helper for partial writes
package clint_1_13_pkg;

    localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
    localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

    typedef enum logic {IDLE, RESP} clint_state_t;

    typedef logic [63:0] mtime_t;

    // Replace only the byte lanes selected by be.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        return res;
    endfunction

endpackage

// File: rtl/priv_1_13_clint_prescaler.sv
// mtime tick generator, built only when CLINT_PRESCALER_EN is defined.
//   CLK, nRST : clock, async active-low reset
//   tick      : high one cycle out of every PRESCALE
// The counter free-runs; bus traffic never touches it.
`ifdef CLINT_PRESCALER_EN
module priv_1_13_clint_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic CLK,
    input  logic nRST,
    output logic tick
);
    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) cnt <= '0;
        else       cnt <= tick ? 16'd0 : cnt + 16'd1;
    end
endmodule
`endif

// File: rtl/priv_1_13_clint.sv
// Machine-mode core-local interruptor: msip, mtimecmp and mtime behind a
// two-state request/busy slave port.
//   CLK, nRST                 : clock, async active-low reset
//   addr/wdata/byte_en/ren/wen: request (held by master until busy=0)
//   rdata/busy/error          : response, valid in the RESP cycle
//   timer_int_m, soft_int_m   : level interrupt sources
//   clear_timer_int_m/_soft_  : one-cycle pulse the cycle after a source falls
// Optional feature macro: CLINT_PRESCALER_EN (mtime ticks every PRESCALE cycles).
module priv_1_13_clint
    import clint_1_13_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          PRESCALE  = 1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byte_en,
    input  logic        ren,
    input  logic        wen,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        error,
    output logic        timer_int_m,
    output logic        soft_int_m,
    output logic        clear_timer_int_m,
    output logic        clear_soft_int_m
);

    clint_state_t state;
    mtime_t       mtime, mtimecmp, mtime_next, mtime_inc;
    logic         msip, msip_d, timer_d, tick;

    // Request captured on IDLE->RESP so the response and the commit do not
    // depend on the master keeping the bus stable through RESP.
    logic [15:0]  req_off;
    logic [31:0]  req_wdata;
    logic [3:0]   req_be;
    logic         req_wr;

    logic         hit_msip, hit_cmp_lo, hit_cmp_hi, hit_time_lo, hit_time_hi;
    logic         mapped, commit;
    logic [31:0]  rd_val;

    // Only the low 16 bits of the window offset are decoded.
    logic [31:0]  rel;
    logic         unused_rel_hi;
    assign rel           = addr - BASE_ADDR;
    assign unused_rel_hi = ^rel[31:16];

`ifdef CLINT_PRESCALER_EN
    priv_1_13_clint_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .CLK  (CLK),
        .nRST (nRST),
        .tick (tick)
    );
`else
    // PRESCALE has no effect without the prescaler.
    logic unused_prescale;
    assign unused_prescale = (PRESCALE == 1);
    assign tick            = 1'b1;
`endif

    // Exact offset matches; a misaligned address can never match.
    always_comb begin
        hit_msip    = (req_off == CLINT_MSIP_OFF);
        hit_cmp_lo  = (req_off == CLINT_MTIMECMP_OFF);
        hit_cmp_hi  = (req_off == CLINT_MTIMECMP_OFF + 16'd4);
        hit_time_lo = (req_off == CLINT_MTIME_OFF);
        hit_time_hi = (req_off == CLINT_MTIME_OFF + 16'd4);
        mapped      = hit_msip | hit_cmp_lo | hit_cmp_hi | hit_time_lo | hit_time_hi;
        commit      = (state == RESP) && req_wr && mapped;
    end

    always_comb begin
        rd_val = '0;
        if (hit_msip)    rd_val = {31'd0, msip};
        if (hit_cmp_lo)  rd_val = mtimecmp[31:0];
        if (hit_cmp_hi)  rd_val = mtimecmp[63:32];
        if (hit_time_lo) rd_val = mtime[31:0];
        if (hit_time_hi) rd_val = mtime[63:32];
    end

    assign busy  = (state == IDLE) && (ren || wen);
    assign rdata = (state == RESP) ? rd_val : 32'd0;
    assign error = (state == RESP) && !mapped;

    assign soft_int_m = msip;

    // A write to one half overrides that half only; the other half keeps the
    // normal increment, including the low->high carry.
    always_comb begin
        mtime_inc  = mtime + {63'd0, tick};
        mtime_next = mtime_inc;
        if (commit && hit_time_lo)
            mtime_next = {mtime_inc[63:32], merge_bytes(mtime[31:0], req_wdata, req_be)};
        if (commit && hit_time_hi)
            mtime_next = {merge_bytes(mtime[63:32], req_wdata, req_be), mtime_inc[31:0]};
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state             <= IDLE;
            req_off           <= '0;
            req_wdata         <= '0;
            req_be            <= '0;
            req_wr            <= 1'b0;
            mtime             <= '0;
            mtimecmp          <= '1;
            msip              <= 1'b0;
            msip_d            <= 1'b0;
            timer_int_m       <= 1'b0;
            timer_d           <= 1'b0;
            clear_timer_int_m <= 1'b0;
            clear_soft_int_m  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (ren || wen) begin
                    state     <= RESP;
                    req_off   <= rel[15:0];
                    req_wdata <= wdata;
                    req_be    <= byte_en;
                    req_wr    <= wen;
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase

            mtime <= mtime_next;
            if (commit && hit_cmp_lo)
                mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], req_wdata, req_be);
            if (commit && hit_cmp_hi)
                mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], req_wdata, req_be);
            if (commit && hit_msip && req_be[0])
                msip <= req_wdata[0];

            // Compare the current state; the interrupt lags it by one cycle.
            timer_int_m       <= (mtime >= mtimecmp);
            timer_d           <= timer_int_m;
            clear_timer_int_m <= timer_d & ~timer_int_m;
            msip_d            <= msip;
            clear_soft_int_m  <= msip_d & ~msip;
        end
    end

endmodule
